// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the decode pipeline: decodes all RV32I/RV64I
// immediate formats and presents them behind a 2-entry skid buffer with valid/ready.
module imm_gen_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = 3,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [31:0]           instr_i,
    input  logic [IMM_WIDTH-1:0]  ImmSrc_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] ImmOp_o,
    output logic                  err_o,
    output logic [TAG_WIDTH-1:0]  tag_o
);

    // Every format is built at 64 bits and then narrowed, so one decoder serves both widths.
    function automatic logic [DATA_WIDTH-1:0] decode_imm(input logic [31:0] ins,
                                                         input logic [IMM_WIDTH-1:0] sel);
        logic signed [63:0] full;
        full = '0;
        case (sel)
            3'd0: full = {{52{ins[31]}}, ins[31:20]};
            3'd1: full = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            3'd2: full = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3: full = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'd4: full = {{32{ins[31]}}, ins[31:12], 12'b0};
            3'd5: full = {59'b0, ins[19:15]};
            3'd6: full = (DATA_WIDTH == 64) ? {58'b0, ins[25:20]} : {59'b0, ins[24:20]};
            default: full = '0;
        endcase
        return full[DATA_WIDTH-1:0];
    endfunction

    function automatic logic illegal_sel(input logic [IMM_WIDTH-1:0] sel);
        return sel == '1;
    endfunction

    logic [DATA_WIDTH-1:0] imm_p0;
    logic                  err_p0;
    logic                  unused_opcode;

    logic                  vld_p1, err_p1;
    logic [DATA_WIDTH-1:0] imm_p1;
    logic [TAG_WIDTH-1:0]  tag_p1;
    logic                  sk_vld_p1, sk_err_p1;
    logic [DATA_WIDTH-1:0] sk_imm_p1;
    logic [TAG_WIDTH-1:0]  sk_tag_p1;

    logic accept, drain;

    // Stage p0: combinational decode of the offered instruction
    assign imm_p0        = decode_imm(instr_i, ImmSrc_i);
    assign err_p0        = illegal_sel(ImmSrc_i);
    assign unused_opcode = ^instr_i[6:0];

    assign ready_o = !sk_vld_p1;
    assign accept  = valid_i && ready_o;
    assign drain   = vld_p1 && ready_i;

    // Stage p1: output register plus skid register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_p1    <= 1'b0;
            imm_p1    <= '0;
            err_p1    <= 1'b0;
            tag_p1    <= '0;
            sk_vld_p1 <= 1'b0;
            sk_imm_p1 <= '0;
            sk_err_p1 <= 1'b0;
            sk_tag_p1 <= '0;
        end else if (flush_i) begin
            vld_p1    <= 1'b0;
            sk_vld_p1 <= 1'b0;
        end else if (drain && sk_vld_p1) begin
            vld_p1    <= 1'b1;
            imm_p1    <= sk_imm_p1;
            err_p1    <= sk_err_p1;
            tag_p1    <= sk_tag_p1;
            sk_vld_p1 <= 1'b0;
        end else if (accept && (!vld_p1 || drain)) begin
            vld_p1 <= 1'b1;
            imm_p1 <= imm_p0;
            err_p1 <= err_p0;
            tag_p1 <= tag_i;
        end else if (accept) begin
            sk_vld_p1 <= 1'b1;
            sk_imm_p1 <= imm_p0;
            sk_err_p1 <= err_p0;
            sk_tag_p1 <= tag_i;
        end else if (drain) begin
            vld_p1 <= 1'b0;
        end
    end

    assign valid_o = vld_p1;
    assign ImmOp_o = imm_p1;
    assign err_o   = err_p1;
    assign tag_o   = tag_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: 32- and 64-bit instances share stimulus; a scoreboard
// fed on each accepted input is drained by a monitor on every output transfer.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_ni, flush_i, valid_i, ready_i;
    logic [31:0] instr_i;
    logic [2:0]  ImmSrc_i;
    logic [4:0]  tag_i;

    logic        rdy32, vo32, err32, rdy64, vo64, err64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [4:0]  tag32, tag64;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] i32;
        logic [63:0] i64;
        logic        err;
        logic [4:0]  tag;
    } item_t;
    item_t q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.DATA_WIDTH(32), .IMM_WIDTH(3), .TAG_WIDTH(5)) u32 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy32),
        .instr_i(instr_i), .ImmSrc_i(ImmSrc_i), .tag_i(tag_i), .valid_o(vo32),
        .ready_i(ready_i), .ImmOp_o(imm32), .err_o(err32), .tag_o(tag32));

    imm_gen_pipe #(.DATA_WIDTH(64), .IMM_WIDTH(3), .TAG_WIDTH(5)) u64 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy64),
        .instr_i(instr_i), .ImmSrc_i(ImmSrc_i), .tag_i(tag_i), .valid_o(vo64),
        .ready_i(ready_i), .ImmOp_o(imm64), .err_o(err64), .tag_o(tag64));

    // Two's-complement interpretation of an n-bit field.
    function automatic longint sgn(input longint x, input int n);
        if (x >= (longint'(1) << (n - 1))) return x - (longint'(1) << n);
        return x;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel,
                                            input int dw);
        longint v;
        case (sel)
            3'd0: v = sgn(longint'(ins[31:20]), 12);
            3'd1: v = sgn(longint'({ins[31:25], ins[11:7]}), 12);
            3'd2: v = sgn(longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
            3'd3: v = sgn(longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
            3'd4: v = sgn(longint'(ins[31:12]), 20) * 4096;
            3'd5: v = longint'(ins[19:15]);
            3'd6: v = (dw == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: v = 0;
        endcase
        if (dw == 32) return {32'b0, v[31:0]};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus side: record the expected response whenever an input is accepted.
    always @(posedge clk) begin
        if (rst_ni && !flush_i && valid_i && rdy32) begin
            item_t it;
            logic [63:0] w;
            w      = ref_imm(instr_i, ImmSrc_i, 32);
            it.i32 = w[31:0];
            it.i64 = ref_imm(instr_i, ImmSrc_i, 64);
            it.err = (ImmSrc_i == 3'd7);
            it.tag = tag_i;
            q.push_back(it);
        end
    end

    // Monitor: occupancy-based handshake checks, hold-while-stalled, in-order data.
    bit          stall_prev = 1'b0;
    logic [37:0] hold_vec;
    always @(negedge clk) begin
        if (!rst_ni || flush_i) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            check("ready_o32", rdy32, q.size() < 2);
            check("ready_o64", rdy64, q.size() < 2);
            check("valid_o32", vo32, q.size() != 0);
            check("valid_o64", vo64, q.size() != 0);
            if (stall_prev) check("hold_stable", {imm32, err32, tag32}, hold_vec);
            if (vo32 && ready_i && q.size() != 0) begin
                item_t e;
                e = q.pop_front();
                check("imm32", imm32, e.i32);
                check("imm64", imm64, e.i64);
                check("err32", err32, e.err);
                check("err64", err64, e.err);
                check("tag32", tag32, e.tag);
                check("tag64", tag64, e.tag);
            end
            stall_prev = vo32 && !ready_i;
            hold_vec   = {imm32, err32, tag32};
        end
    end

    task automatic offer(input logic [31:0] ins, input logic [2:0] sel, input logic [4:0] tg);
        bit done;
        done     = 1'b0;
        instr_i  = ins;
        ImmSrc_i = sel;
        tag_i    = tg;
        valid_i  = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = rdy32 && rst_ni && !flush_i;
            tick();
        end
        valid_i = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL offer_timeout: tag %h never accepted", tg);
        end
    endtask

    logic [31:0] t2_ins [4] = '{32'hFE20AE23, 32'hFE000CE3, 32'h123450B7, 32'h01F09093};
    logic [2:0]  t2_sel [4] = '{3'd1, 3'd2, 3'd4, 3'd6};
    logic [31:0] t2_exp [4] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h0000001F};

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        instr_i = '0; ImmSrc_i = '0; tag_i = '0;
        repeat (3) tick();
        check("rst_valid", {vo32, vo64}, 2'b00);
        check("rst_imm32", imm32, 0);
        check("rst_imm64", imm64, 0);
        check("rst_err_tag", {err32, err64, tag32, tag64}, 0);
        check("rst_ready", {rdy32, rdy64}, 2'b11);
        rst_ni = 1'b1;
        tick();

        // addi x1,x0,-1 on both widths
        ready_i = 1'b1;
        offer(32'hFFF00093, 3'd0, 5'h03);
        check("t1_valid", vo32, 1);
        check("t1_imm32", imm32, 32'hFFFFFFFF);
        check("t1_imm64", imm64, 64'hFFFFFFFF_FFFFFFFF);
        check("t1_err", err32, 0);

        // back-to-back formats, one result per cycle
        for (int i = 0; i < 4; i++) begin
            offer(t2_ins[i], t2_sel[i], 5'(i + 4));
            check("t2_imm32", imm32, t2_exp[i]);
        end
        offer(32'h03F09093, 3'd6, 5'h08);
        check("t6_sh64", imm64, 64'h3F);
        check("t6_sh32", imm32, 32'h1F);
        tick(); tick();

        // stall: first to OUT, second to skid, third held upstream
        ready_i = 1'b0;
        offer(32'h00500093, 3'd0, 5'h11);
        offer(32'h00600093, 3'd0, 5'h12);
        instr_i = 32'h00700093; ImmSrc_i = 3'd0; tag_i = 5'h13; valid_i = 1'b1;
        tick(); tick();
        check("t3_ready_low", rdy32, 0);
        check("t3_head_tag", {vo32, tag32}, {1'b1, 5'h11});
        ready_i = 1'b1;
        tick();
        check("t3_skid_tag", tag32, 5'h12);
        offer(32'h00700093, 3'd0, 5'h13);
        check("t3_third_tag", tag32, 5'h13);

        // illegal select
        offer($urandom, 3'd7, 5'h1A);
        check("t4_imm", imm32, 0);
        check("t4_err_tag", {err32, err64, tag32, tag64}, {2'b11, 5'h1A, 5'h1A});
        tick(); tick();

        // flush a full buffer while a new entry is offered
        ready_i = 1'b0;
        offer(32'h12300093, 3'd0, 5'h1B);
        offer(32'h45600093, 3'd0, 5'h1C);
        instr_i = 32'h78900093; tag_i = 5'h1D; valid_i = 1'b1; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        check("t5_valid", {vo32, vo64}, 2'b00);
        check("t5_ready", {rdy32, rdy64}, 2'b11);
        ready_i = 1'b1;
        repeat (3) tick();

        // reset in the middle of a stall
        ready_i = 1'b0;
        offer(32'hFFF00093, 3'd0, 5'h15);
        offer(32'hFE20AE23, 3'd1, 5'h16);
        rst_ni = 1'b0;
        tick();
        check("t6_rst_valid", {vo32, vo64}, 2'b00);
        check("t6_rst_data", {imm32, err32, tag32}, 0);
        check("t6_rst_data64", {imm64[31:0], err64, tag64}, 0);
        check("t6_rst_ready", {rdy32, rdy64}, 2'b11);
        rst_ni = 1'b1;
        tick();

        // randomized traffic with stalls, flushes and occasional reset
        begin
            bit acc;
            acc = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                if (!valid_i || acc) begin
                    valid_i  = ($urandom_range(0, 9) < 7);
                    instr_i  = $urandom;
                    ImmSrc_i = 3'($urandom_range(0, 7));
                    tag_i    = 5'($urandom);
                end
                ready_i = ($urandom_range(0, 3) != 0);
                flush_i = ($urandom_range(0, 39) == 0);
                rst_ni  = ($urandom_range(0, 299) != 0);
                @(negedge clk);
                acc = valid_i && rdy32 && rst_ni && !flush_i;
                tick();
            end
        end
        valid_i = 1'b0; flush_i = 1'b0; rst_ni = 1'b1; ready_i = 1'b1;
        repeat (5) tick();
        check("drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
